// File: rtl/regfile_wr_arbiter.sv
// Round-robin arbiter sharing the single regfile write port between execute
// writeback (A) and the load-return unit (B), plus a scoreboard of outstanding loads.
module regfile_wr_arbiter #(
  parameter int DW = 64,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          a_valid,
  output logic          a_ready,
  input  logic [AW-1:0] a_wa,
  input  logic [DW-1:0] a_wd,
  input  logic          b_valid,
  output logic          b_ready,
  input  logic [AW-1:0] b_wa,
  input  logic [DW-1:0] b_wd,
  input  logic          issue_valid,
  input  logic [AW-1:0] issue_wa,
  input  logic [AW-1:0] chk_ra1,
  input  logic [AW-1:0] chk_ra2,
  output logic          busy1,
  output logic          busy2,
  output logic          busy_any,
  output logic          we3,
  output logic [AW-1:0] wa3,
  output logic [DW-1:0] wd3
);

  localparam int            NREG    = 2 ** AW;
  localparam logic [AW-1:0] XZR     = {AW{1'b1}};
  localparam logic [5:0]    CNT_MAX = 6'd31;

  // Handshake: a write transfers in the cycle where valid && ready are both 1.
  // ready is a pure function of this cycle's valids, the RR pointer and reset,
  // so a requester may drop valid freely and never sees ready without valid.

  logic            rr_b;      // 0: A wins a tie, 1: B wins a tie
  logic            src_b;     // source of the write currently in the output stage
  logic [NREG-1:0] sb;
  logic [NREG-1:0] sb_next;
  logic [5:0]      ld_cnt;
  logic            grant_a;
  logic            grant_b;
  logic            commit_b;
  logic            issue_set;

  assign grant_a = !reset && a_valid && (!b_valid || !rr_b);
  assign grant_b = !reset && b_valid && (!a_valid ||  rr_b);
  assign a_ready = grant_a;
  assign b_ready = grant_b;

  // Output stage and round-robin pointer
  always_ff @(posedge clk) begin
    if (reset) begin
      we3   <= 1'b0;
      wa3   <= '0;
      wd3   <= '0;
      src_b <= 1'b0;
      rr_b  <= 1'b0;
    end else if (grant_a) begin
      we3   <= (a_wa != XZR);
      wa3   <= a_wa;
      wd3   <= a_wd;
      src_b <= 1'b0;
      rr_b  <= 1'b1;
    end else if (grant_b) begin
      we3   <= (b_wa != XZR);
      wa3   <= b_wa;
      wd3   <= b_wd;
      src_b <= 1'b1;
      rr_b  <= 1'b0;
    end else begin
      we3   <= 1'b0;
    end
  end

  // A load return retires its scoreboard bit on the edge the regfile commits it.
  assign commit_b  = we3 && src_b;
  assign issue_set = issue_valid && (issue_wa != XZR);

  always_comb begin
    sb_next = sb;
    if (commit_b)  sb_next[wa3]      = 1'b0;
    if (issue_set) sb_next[issue_wa] = 1'b1;
    sb_next[XZR] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) sb <= '0;
    else       sb <= sb_next;
  end

  assign busy1    = sb[chk_ra1];
  assign busy2    = sb[chk_ra2];
  assign busy_any = |sb;

  // Outstanding-load count, kept only as a sanity reference for assertions.
  always_ff @(posedge clk) begin
    if (reset) begin
      ld_cnt <= '0;
    end else if (issue_set && !commit_b) begin
      if (ld_cnt != CNT_MAX) ld_cnt <= ld_cnt + 6'd1;
    end else if (commit_b && !issue_set) begin
      if (ld_cnt != 6'd0) ld_cnt <= ld_cnt - 6'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!(a_ready && b_ready));
      assert (!(we3 && (wa3 == XZR)));
      assert (ld_cnt <= CNT_MAX);
      assert (!sb[XZR]);
    end
  end

endmodule
